// File: rtl/feistel_round_seq_pkg.sv
// Shared types and constants for the Feistel round sequencer.
// Also hosts the word-reversal helper used when FEISTEL_FINAL_SWAP_EN is defined.
package feistel_round_seq_pkg;

    localparam int WORD_W         = 32;
    localparam int BLK_W          = 128;
    localparam int NUM_WORDS      = BLK_W / WORD_W;
    localparam int DEF_NUM_ROUNDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Word 0 occupies bits [0:31]; the result places the last word first.
    function automatic logic [0:BLK_W-1] word_reverse(input logic [0:BLK_W-1] blk);
        logic [0:BLK_W-1] r;
        r = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            r[i*WORD_W +: WORD_W] = blk[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/feistel_round_seq.sv
// Iterative sequencer: holds one 128-bit block and steps an external round datapath NUM_ROUNDS times.
// Optional macro FEISTEL_FINAL_SWAP_EN word-reverses the returned block.
module feistel_round_seq
    import feistel_round_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int RIDX_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dec,
    input  logic [0:BLK_W-1]  in_data,
    output logic [0:BLK_W-1]  rnd_state,
    output logic [RIDX_W-1:0] rnd_idx,
    input  logic [0:BLK_W-1]  rnd_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:BLK_W-1]  out_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and out_data is held while
    // out_valid is high and out_ready is low.

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

    fsm_t              fsm;
    logic [0:BLK_W-1]  state;
    logic [RIDX_W-1:0] cnt;
    logic              dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm   <= ST_IDLE;
            state <= '0;
            cnt   <= '0;
            dec   <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= in_data;
                        dec   <= in_dec;
                        cnt   <= '0;
                        fsm   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state <= rnd_result;
                    if (cnt == LAST_IDX) begin
                        cnt <= '0;
                        fsm <= ST_DONE;
                    end else begin
                        cnt <= cnt + RIDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE first keeps accept and output handshakes in separate cycles.
                    if (out_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == ST_IDLE) && rst_n;
    assign out_valid = (fsm == ST_DONE);
    assign busy      = (fsm != ST_IDLE);
    assign dbg_state = fsm;

    // Decrypt walks the key schedule backwards from the last round key.
    assign rnd_idx   = dec ? (LAST_IDX - cnt) : cnt;
    assign rnd_state = state;

`ifdef FEISTEL_FINAL_SWAP_EN
    assign out_data = word_reverse(state);
`else
    assign out_data = state;
`endif

endmodule

// File: tb/tb_feistel_round_seq.sv
// Self-checking bench for feistel_round_seq with a stub round datapath {w1, w2, w3, w0 ^ idx}.
// Directed scenarios plus randomized blocks checked by a scoreboard against a word-level model.
module tb_feistel_round_seq;

    localparam int N  = 4;
    localparam int RW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_dec;
    logic [0:127]  in_data;
    logic [0:127]  rnd_state;
    logic [RW-1:0] rnd_idx;
    logic [0:127]  rnd_result;
    logic          out_valid;
    logic          out_ready;
    logic [0:127]  out_data;
    logic          busy;
    logic [1:0]    dbg_state;

    feistel_round_seq #(.NUM_ROUNDS(N), .RIDX_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dec     (in_dec),
        .in_data    (in_data),
        .rnd_state  (rnd_state),
        .rnd_idx    (rnd_idx),
        .rnd_result (rnd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Stub round datapath
    assign rnd_result = {rnd_state[32:63], rnd_state[64:95], rnd_state[96:127],
                         rnd_state[0:31] ^ {{(32-RW){1'b0}}, rnd_idx}};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [127:0]  exp_q[$];
    logic [RW-1:0] idx_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int acc_cyc = 0;
    bit rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: rotate words left, fold the round index into the old word 0.
    function automatic logic [0:127] ref_model(input logic [0:127] blk, input logic dec);
        logic [31:0] w[4];
        logic [31:0] t;
        int k;
        for (int j = 0; j < 4; j++) w[j] = blk[j*32 +: 32];
        for (int r = 0; r < N; r++) begin
            k = dec ? (N - 1 - r) : r;
            t = w[0];
            w[0] = w[1];
            w[1] = w[2];
            w[2] = w[3];
            w[3] = t ^ 32'(k);
        end
`ifdef FEISTEL_FINAL_SWAP_EN
        return {w[3], w[2], w[1], w[0]};
`else
        return {w[0], w[1], w[2], w[3]};
`endif
    endfunction

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic send(input logic [0:127] d, input logic dec, input logic [0:127] exp);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_dec   = dec;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(exp);
            for (int i = 0; i < N; i++) idx_q.push_back(RW'(dec ? (N - 1 - i) : i));
            acc_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("out_valid_timeout", 128'(out_valid), 128'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    // Random backpressure generator, enabled only during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor ----------------
    logic [RW-1:0] exp_idx;
    always @(negedge clk) begin
        if (busy && !out_valid) begin
            if (idx_q.size() == 0) begin
                check("rnd_idx_unexpected", 128'(rnd_idx), 128'(0) - 128'(1));
            end else begin
                exp_idx = idx_q.pop_front();
                check("rnd_idx", 128'(rnd_idx), 128'(exp_idx));
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", out_data, 128'(0) - 128'(1));
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- main sequence ----------------
    localparam logic [0:127] BLK_1234 = 128'h00000001_00000002_00000003_00000004;
`ifdef FEISTEL_FINAL_SWAP_EN
    localparam logic [0:127] ENC_EXP = 128'h00000007_00000001_00000003_00000001;
    localparam logic [0:127] DEC_EXP = 128'h00000004_00000002_00000000_00000002;
`else
    localparam logic [0:127] ENC_EXP = 128'h00000001_00000003_00000001_00000007;
    localparam logic [0:127] DEC_EXP = 128'h00000002_00000000_00000002_00000004;
`endif

    initial begin
        bit ok;
        bit seen;
        int a1;
        int a2;
        logic [0:127] held;
        logic [0:127] d;
        logic dr;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_dec = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 128'(in_ready), 128'(0));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_rnd_state", rnd_state, 128'(0));
        check("reset_rnd_idx", 128'(rnd_idx), 128'(0));
        check("reset_out_data", out_data, 128'(0));
        check("reset_fsm", 128'(dbg_state), 128'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Encrypt with latency check
        out_ready = 1'b1;
        send(BLK_1234, 1'b0, ENC_EXP);
        in_valid = 1'b0;
        a1 = acc_cyc;
        wait_valid(50, ok);
        if (ok) check("enc_latency", 128'(cyc - a1), 128'(N));
        drain();

        // Decrypt
        send(BLK_1234, 1'b1, DEC_EXP);
        in_valid = 1'b0;
        drain();

        // Backpressure: hold DONE for 10 cycles
        out_ready = 1'b0;
        send(BLK_1234, 1'b0, ENC_EXP);
        in_valid = 1'b0;
        wait_valid(50, ok);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_out_data_stable", out_data, held);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        check("bp_in_ready_at_release", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 128'(in_ready), 128'(1));
        check("bp_out_valid_after", 128'(out_valid), 128'(0));
        drain();

        // Back-to-back with in_valid held high through RUN
        d = {$urandom, $urandom, $urandom, $urandom};
        send(BLK_1234, 1'b1, DEC_EXP);
        a1 = acc_cyc;
        send(d, 1'b0, ref_model(d, 1'b0));
        a2 = acc_cyc;
        in_valid = 1'b0;
        check("accept_spacing", 128'(a2 - a1), 128'(N + 2));
        drain();

        // Reset during round 2 discards the block
        send(BLK_1234, 1'b0, ENC_EXP);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        idx_q.delete();
        check("midrst_fsm", 128'(dbg_state), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_rnd_state", rnd_state, 128'(0));
        check("midrst_rnd_idx", 128'(rnd_idx), 128'(0));
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("midrst_no_output", 128'(seen), 128'(0));

        // Randomized blocks with random backpressure
        rand_ready_en = 1'b1;
        for (int b = 0; b < 24; b++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            dr = 1'($urandom_range(0, 1));
            send(d, dr, ref_model(d, dr));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready_en = 1'b0;
        out_ready = 1'b1;
        drain();
        check("idx_queue_empty", 128'(idx_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
